uart_mmio_port: RTL and testbench
=================================

// Module: uart_mmio_port
// PURPOSE
//  Memory-mapped UART peripheral with parametrised TX/RX FIFOs and a programmable baud divisor.
//  Successor to the bare uart + IO/status mux path, sitting on the MMIO side of the datapath.
//  Core bus reads DATA/STATUS/DIV registers through one port.
//  Adds sticky error flags, runtime baud selection and an optional interrupt.
// PARAMETERS
//  CLK_FREQ    50000000  system clock in Hz
//  BAUD        115200    reset baud; DIV_RST = CLK_FREQ/(16*BAUD), truncated (27 at defaults)
//  DATA_BITS   8         frame data bits, 5..8; unused wdata/rdata upper bits ignored/read 0
//  FIFO_AW     4         FIFO address width; each FIFO holds 2**FIFO_AW entries
// PORTS
//  clk      in   1   system clock, rising edge
//  rst      in   1   asynchronous reset, active-low
//  sel      in   1   peripheral select; rd/wr ignored when 0
//  rd       in   1   read strobe, one cycle per access
//  wr       in   1   write strobe, one cycle per access
//  addr     in   3   register index
//  wdata    in   8   write data
//  rdata    out  8   registered read data
//  rx       in   1   serial input, asynchronous
//  tx       out  1   serial output, idle high
//  irq      out  1   level interrupt (UART_IRQ_EN only)
// BEHAVIOUR
//  Register map:
//   0 DATA  rd pops RX FIFO; wr pushes TX FIFO
//   1 STAT  {3'b0, frm_err, tx_drop, rx_ovr, tx_full, rx_empty}; read clears bits 4:2
//   2 DIVLO, 3 DIVHI  16-bit divisor, R/W
//   4 IRQEN  bit0 = rx-not-empty enable, bit1 = tx-empty enable
//   5-7     read 0, writes ignored
//  Reset (rst=0, async):
//   - tx=1, rdata=0, irq=0, flags=0, IRQEN=0, DIV=DIV_RST
//   - FIFOs empty; TX/RX FSMs IDLE; baud counter=0
//  Read latency: 1 cycle; rdata valid the cycle after sel&rd and held until the next read.
//  Access rules:
//   - rd&wr together: write wins, no pop.
//   - Pop of an empty RX FIFO: rdata=0, no pointer change.
//   - Push to a full TX FIFO: data dropped, tx_drop=1.
//  Baud tick:
//   - 16-bit counter counts 0..DIV-1; tick pulses on reload. DIV=0 is treated as 1.
//   - A DIV write takes effect at the next reload; the current frame is not restarted.
//  TX FSM: IDLE -> START -> DATA -> STOP -> IDLE
//   - Each bit lasts 16 ticks; data sent LSB first; one stop bit.
//   - IDLE pops the FIFO when it is non-empty; back-to-back frames have no idle gap.
//  RX FSM: IDLE -> START -> DATA -> STOP -> IDLE
//   - rx passes through a 2-FF synchroniser.
//   - IDLE -> START on synced rx==0 at a tick.
//   - START samples at tick 8; if rx==1 it is a false start, return to IDLE.
//   - DATA: one bit every 16 ticks at mid-bit, LSB first.
//   - STOP sample==0: frm_err=1, byte discarded.
//   - STOP sample==1: push the byte; if RX FIFO is full, rx_ovr=1 and the byte is dropped.
//  FIFO boundaries:
//   - Simultaneous push and pop on a full or empty FIFO are both honoured, except a pop on empty.
//   - Count saturates correctly; pointers wrap modulo 2**FIFO_AW.
//  Flag priority: a flag set in the same cycle as a STAT clear-on-read stays set.
//  Reset mid-frame aborts immediately: tx=1 next edge-independent, partial RX byte lost.
// CONFIGURATION
//  UART_IRQ_EN defined:
//   - irq = (IRQEN[0] & ~rx_empty) | (IRQEN[1] & tx_fifo_empty & tx_idle), registered.
//  UART_IRQ_EN undefined:
//   - irq tied 0; IRQEN reads 0; writes to it are ignored; no IRQ logic synthesised.
// TESTING
//  1 Reset, read STAT -> rdata=8'h01 (rx_empty); tx=1; read DIVLO/DIVHI -> 27/0.
//  2 Write DIV=4; write DATA 8'hA5 -> tx start bit 64 clks; bits 1,0,1,0,0,1,0,1 each 64 clks; stop=1.
//  3 Loop tx->rx at DIV=4; send 8'h3C, 8'hC3 -> two DATA reads return 8'h3C then 8'hC3; STAT=8'h01 after.
//  4 Fill TX with 17 writes at FIFO_AW=4 while serializing -> 16 accepted; STAT bit3=1, then 0 on re-read.
//  5 Receive 17 frames without reading -> 16 bytes stored, rx_ovr=1; frame with stop=0 -> frm_err=1, no push.
//  6 UART_IRQ_EN, IRQEN=1, receive 8'h55 -> irq=1 after stop bit; read DATA -> irq=0 next cycle.

Source files
------------

// File: rtl/uart_mmio_port.sv
// uart_mmio_port: memory-mapped UART with TX/RX FIFOs, runtime baud divisor and sticky errors.
//
// Register map (addr_i): 0 DATA (rd pops RX, wr pushes TX), 1 STAT (read clears bits 4:2),
// 2 DIVLO, 3 DIVHI, 4 IRQEN, 5-7 read 0.
// STAT = {3'b0, frm_err, tx_drop, rx_ovr, tx_full, rx_empty}.
//
// Ports:
//   clk_i     system clock, rising edge
//   rst_ni    asynchronous reset, active low
//   sel_i     peripheral select; rd_i/wr_i ignored when low
//   rd_i      read strobe (one cycle per access); wr_i write strobe (write wins over read)
//   addr_i    register index
//   wdata_i   write data
//   rdata_o   registered read data, valid the cycle after a read and held until the next read
//   rx_i      asynchronous serial input
//   tx_o      serial output, idle high
//   irq_o     level interrupt
//
// Build option: define UART_IRQ_EN to include the IRQEN register and interrupt logic;
// otherwise irq_o is tied low and IRQEN reads 0.

module uart_mmio_port #(
   parameter int unsigned CLK_FREQ  = 50000000,
   parameter int unsigned BAUD      = 115200,
   parameter int unsigned DATA_BITS = 8,
   parameter int unsigned FIFO_AW   = 4
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       sel_i,
   input  logic       rd_i,
   input  logic       wr_i,
   input  logic [2:0] addr_i,
   input  logic [7:0] wdata_i,
   output logic [7:0] rdata_o,
   input  logic       rx_i,
   output logic       tx_o,
   output logic       irq_o
);

   localparam logic [15:0] DivRst = 16'(CLK_FREQ / (16 * BAUD));
   localparam logic [15:0] DivRstEff = (DivRst == 16'd0) ? 16'd1 : DivRst;
   localparam int unsigned DW = DATA_BITS;
   localparam logic [FIFO_AW:0] Depth = (FIFO_AW + 1)'(2 ** FIFO_AW);
   localparam logic [2:0] LastBit = 3'(DATA_BITS - 1);

   typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;
   typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

   // Bus decode: a write beats a simultaneous read, so the read (and its pop) is suppressed.
   logic acc_wr, acc_rd;
   assign acc_wr = sel_i & wr_i;
   assign acc_rd = sel_i & rd_i & ~wr_i;

   // Baud tick generator; a new divisor is picked up only on reload.
   logic [15:0] div_q, act_div_q, bcnt_q;
   logic        tick;
   assign tick = (bcnt_q == act_div_q - 16'd1);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         bcnt_q    <= '0;
         act_div_q <= DivRstEff;
      end else if (tick) begin
         bcnt_q    <= '0;
         act_div_q <= (div_q == 16'd0) ? 16'd1 : div_q;
      end else begin
         bcnt_q <= bcnt_q + 16'd1;
      end
   end

   // TX FIFO
   logic [DW-1:0]    tx_mem [2**FIFO_AW];
   logic [FIFO_AW-1:0] tx_wp_q, tx_rp_q;
   logic [FIFO_AW:0] tx_cnt_q, tx_cnt_d;
   logic             tx_empty, tx_full, tx_wr_req, tx_push, tx_pop, tx_drop_set;
   tx_state_e        tx_st_q;
   logic [3:0]       tx_tcnt_q;
   logic [2:0]       tx_bit_q;
   logic [DW-1:0]    tx_sh_q;
   logic             tx_q;

   assign tx_empty    = (tx_cnt_q == '0);
   assign tx_full     = (tx_cnt_q == Depth);
   assign tx_wr_req   = acc_wr & (addr_i == 3'd0);
   assign tx_pop      = tick & ~tx_empty &
                        ((tx_st_q == TxIdle) | ((tx_st_q == TxStop) & (tx_tcnt_q == 4'hF)));
   // A push into a full FIFO still lands when the serializer pops in the same cycle.
   assign tx_push     = tx_wr_req & (~tx_full | tx_pop);
   assign tx_drop_set = tx_wr_req & ~tx_push;
   assign tx_cnt_d    = tx_cnt_q + (FIFO_AW + 1)'(tx_push) - (FIFO_AW + 1)'(tx_pop);

   always_ff @(posedge clk_i) begin
      if (tx_push) tx_mem[tx_wp_q] <= wdata_i[DW-1:0];
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         tx_wp_q  <= '0;
         tx_rp_q  <= '0;
         tx_cnt_q <= '0;
      end else begin
         if (tx_push) tx_wp_q <= tx_wp_q + 1'b1;
         if (tx_pop)  tx_rp_q <= tx_rp_q + 1'b1;
         tx_cnt_q <= tx_cnt_d;
      end
   end

   // TX FSM: every state lasts 16 ticks; a pending byte is loaded straight from STOP.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         tx_st_q   <= TxIdle;
         tx_tcnt_q <= '0;
         tx_bit_q  <= '0;
         tx_sh_q   <= '0;
         tx_q      <= 1'b1;
      end else if (tick) begin
         unique case (tx_st_q)
            TxIdle: begin
               if (tx_pop) begin
                  tx_sh_q   <= tx_mem[tx_rp_q];
                  tx_q      <= 1'b0;
                  tx_tcnt_q <= '0;
                  tx_st_q   <= TxStart;
               end
            end
            TxStart: begin
               tx_tcnt_q <= tx_tcnt_q + 4'd1;
               if (tx_tcnt_q == 4'hF) begin
                  tx_q     <= tx_sh_q[0];
                  tx_bit_q <= '0;
                  tx_st_q  <= TxData;
               end
            end
            TxData: begin
               tx_tcnt_q <= tx_tcnt_q + 4'd1;
               if (tx_tcnt_q == 4'hF) begin
                  if (tx_bit_q == LastBit) begin
                     tx_q    <= 1'b1;
                     tx_st_q <= TxStop;
                  end else begin
                     tx_bit_q <= tx_bit_q + 3'd1;
                     tx_sh_q  <= tx_sh_q >> 1;
                     tx_q     <= tx_sh_q[1];
                  end
               end
            end
            TxStop: begin
               tx_tcnt_q <= tx_tcnt_q + 4'd1;
               if (tx_tcnt_q == 4'hF) begin
                  if (tx_pop) begin
                     tx_sh_q <= tx_mem[tx_rp_q];
                     tx_q    <= 1'b0;
                     tx_st_q <= TxStart;
                  end else begin
                     tx_st_q <= TxIdle;
                  end
               end
            end
         endcase
      end
   end
   assign tx_o = tx_q;

   // RX synchroniser and FSM
   logic [1:0]    rx_sync_q;
   logic          rx_s;
   rx_state_e     rx_st_q;
   logic [3:0]    rx_tcnt_q;
   logic [2:0]    rx_bit_q;
   logic [DW-1:0] rx_sh_q;
   logic          rx_stop_smp, rx_push_req, frm_set;

   assign rx_s        = rx_sync_q[1];
   assign rx_stop_smp = tick & (rx_st_q == RxStop) & (rx_tcnt_q == 4'hF);
   assign rx_push_req = rx_stop_smp & rx_s;
   assign frm_set     = rx_stop_smp & ~rx_s;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rx_sync_q <= 2'b11;
         rx_st_q   <= RxIdle;
         rx_tcnt_q <= '0;
         rx_bit_q  <= '0;
         rx_sh_q   <= '0;
      end else begin
         rx_sync_q <= {rx_sync_q[0], rx_i};
         if (tick) begin
            unique case (rx_st_q)
               RxIdle: begin
                  if (!rx_s) begin
                     rx_tcnt_q <= '0;
                     rx_st_q   <= RxStart;
                  end
               end
               RxStart: begin
                  rx_tcnt_q <= rx_tcnt_q + 4'd1;
                  // Mid start bit: a high line here means a glitch, not a frame.
                  if (rx_tcnt_q == 4'd7) begin
                     rx_tcnt_q <= '0;
                     rx_bit_q  <= '0;
                     rx_st_q   <= rx_s ? RxIdle : RxData;
                  end
               end
               RxData: begin
                  rx_tcnt_q <= rx_tcnt_q + 4'd1;
                  if (rx_tcnt_q == 4'hF) begin
                     rx_sh_q <= {rx_s, rx_sh_q[DW-1:1]};
                     if (rx_bit_q == LastBit) rx_st_q <= RxStop;
                     else                     rx_bit_q <= rx_bit_q + 3'd1;
                  end
               end
               RxStop: begin
                  rx_tcnt_q <= rx_tcnt_q + 4'd1;
                  if (rx_tcnt_q == 4'hF) rx_st_q <= RxIdle;
               end
            endcase
         end
      end
   end

   // RX FIFO
   logic [DW-1:0]      rx_mem [2**FIFO_AW];
   logic [FIFO_AW-1:0] rx_wp_q, rx_rp_q;
   logic [FIFO_AW:0]   rx_cnt_q, rx_cnt_d;
   logic               rx_empty, rx_full, rx_push, rx_pop, rx_ovr_set;

   assign rx_empty   = (rx_cnt_q == '0);
   assign rx_full    = (rx_cnt_q == Depth);
   assign rx_pop     = acc_rd & (addr_i == 3'd0) & ~rx_empty;
   assign rx_push    = rx_push_req & (~rx_full | rx_pop);
   assign rx_ovr_set = rx_push_req & ~rx_push;
   assign rx_cnt_d   = rx_cnt_q + (FIFO_AW + 1)'(rx_push) - (FIFO_AW + 1)'(rx_pop);

   always_ff @(posedge clk_i) begin
      if (rx_push) rx_mem[rx_wp_q] <= rx_sh_q;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rx_wp_q  <= '0;
         rx_rp_q  <= '0;
         rx_cnt_q <= '0;
      end else begin
         if (rx_push) rx_wp_q <= rx_wp_q + 1'b1;
         if (rx_pop)  rx_rp_q <= rx_rp_q + 1'b1;
         rx_cnt_q <= rx_cnt_d;
      end
   end

   // Registers, sticky flags and read mux
   logic       frm_q, drop_q, ovr_q, stat_clr;
   logic [7:0] rd_val, rdata_q;
   assign stat_clr = acc_rd & (addr_i == 3'd1);

`ifdef UART_IRQ_EN
   logic [1:0] irqen_q;
   logic       irq_q;
`endif

   always_comb begin
      rd_val = '0;
      case (addr_i)
         3'd0: if (!rx_empty) rd_val[DW-1:0] = rx_mem[rx_rp_q];
         3'd1: rd_val = {3'b000, frm_q, drop_q, ovr_q, tx_full, rx_empty};
         3'd2: rd_val = div_q[7:0];
         3'd3: rd_val = div_q[15:8];
`ifdef UART_IRQ_EN
         3'd4: rd_val = {6'd0, irqen_q};
`endif
         default: rd_val = '0;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         div_q   <= DivRst;
         frm_q   <= 1'b0;
         drop_q  <= 1'b0;
         ovr_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         // Set beats clear-on-read so an event in the read cycle is never lost.
         frm_q  <= (frm_q & ~stat_clr) | frm_set;
         drop_q <= (drop_q & ~stat_clr) | tx_drop_set;
         ovr_q  <= (ovr_q & ~stat_clr) | rx_ovr_set;
         if (acc_rd) rdata_q <= rd_val;
         if (acc_wr && addr_i == 3'd2) div_q[7:0]  <= wdata_i;
         if (acc_wr && addr_i == 3'd3) div_q[15:8] <= wdata_i;
      end
   end
   assign rdata_o = rdata_q;

`ifdef UART_IRQ_EN
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         irqen_q <= '0;
         irq_q   <= 1'b0;
      end else begin
         if (acc_wr && addr_i == 3'd4) irqen_q <= wdata_i[1:0];
         // Next-state FIFO counts so a DATA read drops irq on the very next edge.
         irq_q <= (irqen_q[0] & (rx_cnt_d != '0)) |
                  (irqen_q[1] & (tx_cnt_d == '0) & (tx_st_q == TxIdle));
      end
   end
   assign irq_o = irq_q;
`else
   assign irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_mmio_port.sv
module tb_uart_mmio_port;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       sel = 1'b0, rd = 1'b0, wr = 1'b0;
   logic [2:0] addr = '0;
   logic [7:0] wdata = '0;
   logic [7:0] rdata;
   logic       rx, tx, irq;
   logic       rx_drv = 1'b1;
   logic       loop = 1'b0;

   int n_checks = 0;
   int n_pass = 0;

   assign rx = loop ? tx : rx_drv;

   always #5 clk = ~clk;

   uart_mmio_port dut (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .sel_i   (sel),
      .rd_i    (rd),
      .wr_i    (wr),
      .addr_i  (addr),
      .wdata_i (wdata),
      .rdata_o (rdata),
      .rx_i    (rx),
      .tx_o    (tx),
      .irq_o   (irq)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   // Bus tasks are entered at a falling edge and return at a falling edge.
   task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
      sel = 1'b1; wr = 1'b1; addr = a; wdata = d;
      @(negedge clk);
      sel = 1'b0; wr = 1'b0;
   endtask

   task automatic rd_check(input string tag, input logic [2:0] a, input logic [7:0] exp);
      sel = 1'b1; rd = 1'b1; addr = a;
      @(negedge clk);
      sel = 1'b0; rd = 1'b0;
      check(tag, 32'(rdata), 32'(exp));
   endtask

   // One serial frame at 64 clocks per bit (DIV=4).
   task automatic send_frame(input logic [7:0] b, input logic stop);
      rx_drv = 1'b0;
      repeat (64) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx_drv = b[i];
         repeat (64) @(negedge clk);
      end
      rx_drv = stop;
      repeat (64) @(negedge clk);
      rx_drv = 1'b1;
   endtask

   initial begin
      logic [9:0] a5_bits;
      int k;
      int len;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_rdata", 32'(rdata), 32'h0);
      check("rst_tx", 32'(tx), 32'h1);
      check("rst_irq", 32'(irq), 32'h0);
      rst_n = 1'b1;
      @(negedge clk);
      rd_check("rst_stat", 3'd1, 8'h01);
      rd_check("rst_divlo", 3'd2, 8'd27);
      rd_check("rst_divhi", 3'd3, 8'd0);
      rd_check("rst_irqen", 3'd4, 8'h00);
      rd_check("addr5", 3'd5, 8'h00);

      // TX waveform of 8'hA5 at DIV=4
      bus_write(3'd2, 8'd4);
      rd_check("divlo_wr", 3'd2, 8'd4);
      bus_write(3'd0, 8'hA5);
      k = 0;
      while (tx === 1'b1 && k < 400) begin
         @(negedge clk);
         k++;
      end
      check("tx_start_seen", 32'(tx), 32'h0);
      len = 0;
      while (tx === 1'b0 && len < 200) begin
         @(negedge clk);
         len++;
      end
      check("tx_start_len", 32'(len), 32'd64);
      a5_bits = {1'b1, 8'hA5, 1'b0};
      repeat (32) @(negedge clk);
      for (int i = 1; i < 10; i++) begin
         check($sformatf("tx_bit%0d", i - 1), 32'(tx), 32'(a5_bits[i]));
         if (i < 9) repeat (64) @(negedge clk);
      end

      // Loopback of two frames
      loop = 1'b1;
      bus_write(3'd0, 8'h3C);
      bus_write(3'd0, 8'hC3);
      repeat (1500) @(negedge clk);
      rd_check("loop_b0", 3'd0, 8'h3C);
      rd_check("loop_b1", 3'd0, 8'hC3);
      rd_check("loop_stat", 3'd1, 8'h01);
      loop = 1'b0;

      // TX FIFO overflow while a frame is serializing
      bus_write(3'd0, 8'h11);
      repeat (10) @(negedge clk);
      for (int i = 0; i < 17; i++) bus_write(3'd0, 8'(i));
      rd_check("tx_drop_stat", 3'd1, 8'h0B);
      rd_check("tx_drop_clr", 3'd1, 8'h03);
      repeat (11500) @(negedge clk);
      rd_check("tx_drained", 3'd1, 8'h01);

      // RX overflow, framing error, pop order
      for (int i = 0; i < 17; i++) send_frame(8'h40 + 8'(i), 1'b1);
      repeat (20) @(negedge clk);
      rd_check("rx_ovr_stat", 3'd1, 8'h04);
      send_frame(8'h77, 1'b0);
      repeat (64) @(negedge clk);
      rd_check("frm_err_stat", 3'd1, 8'h10);
      rd_check("frm_err_clr", 3'd1, 8'h00);
      for (int i = 0; i < 16; i++) rd_check($sformatf("rx_pop%0d", i), 3'd0, 8'h40 + 8'(i));
      rd_check("rx_empty_stat", 3'd1, 8'h01);
      rd_check("pop_empty", 3'd0, 8'h00);

`ifdef UART_IRQ_EN
      bus_write(3'd4, 8'h01);
      rd_check("irqen_rd", 3'd4, 8'h01);
      check("irq_idle", 32'(irq), 32'h0);
      send_frame(8'h55, 1'b1);
      repeat (10) @(negedge clk);
      check("irq_set", 32'(irq), 32'h1);
      rd_check("irq_data", 3'd0, 8'h55);
      check("irq_clr", 32'(irq), 32'h0);
`else
      bus_write(3'd4, 8'h03);
      rd_check("irqen_off", 3'd4, 8'h00);
      send_frame(8'h55, 1'b1);
      repeat (10) @(negedge clk);
      check("irq_off", 32'(irq), 32'h0);
      rd_check("rx_55", 3'd0, 8'h55);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
